enemy_fire_scheduler: RTL
=========================

# enemy_fire_scheduler

Decides when the alien formation shoots and which alien fires. It paces shots with a reload counter that shortens as `speed_level` rises. It picks a pseudo-random column and selects the lowest living alien in that column, scanning to the next column if needed. It hands the chosen alien's row/column to the enemy-munition datapath over a valid/ready handshake. It sits between the game FSM (`enable`, `speed_level`), the enemy alive vector, and `municao2`, and replaces the free-running `ID_enemy_tiro_X/Y` source.

## Interface
- `LINHAS`, default 4, number of formation rows (1..4).
- `COLUNAS`, default 10, number of columns (8..16).
- `FIRE_PERIOD`, default 24'd6_000_000, base cycles between shots.
- `SPEED_STEP`, default 24'd250_000, period reduction per `speed_level` unit.
- `MIN_PERIOD`, default 24'd1_000_000, floor on the reload value.
- `LFSR_SEED`, default 16'hACE1, LFSR reset value; must be nonzero.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  high only while the game is in the playing state.
- `vivo_inimigo`  in  LINHAS*COLUNAS  alive bit per enemy; index = row*COLUNAS + col; row 0 is the top row.
- `speed_level`  in  5  formation speed level.
- `shot_busy`  in  1  an enemy shot is in flight.
- `fire_ready`  in  1  munition datapath accepts a shot.
- `fire_valid`  out  1  shot request.
- `fire_col`  out  4  column of the firing alien.
- `fire_row`  out  2  row of the firing alien.
- `fire_idx`  out  6  row*COLUNAS + col.
- `no_target`  out  1  one-cycle pulse: a full scan found no living alien.

## Operation
- Reload value R = max(FIRE_PERIOD − speed_level*SPEED_STEP, MIN_PERIOD).
  - Computed in 24-bit unsigned arithmetic.
  - An underflow of the subtraction is treated as MIN_PERIOD.
- 16-bit Galois LFSR, taps 16'hB400, advances every cycle outside reset.
  - Candidate column c = lfsr[3:0] if < COLUNAS, else lfsr[3:0] − COLUNAS.
- State IDLE:
  - Counter decrements while `enable` is high.
  - When counter = 0, `enable` = 1 and `shot_busy` = 0: go to PICK.
  - When counter = 0 and `shot_busy` = 1: hold at 0 until the shot clears.
- State PICK (1 cycle): latch c into col_q, set row_q = LINHAS−1, clear cols_tried; go to SCAN.
- State SCAN (one alive bit per cycle):
  - If bit[row_q*COLUNAS + col_q] = 1: go to ISSUE.
  - Otherwise, if row_q > 0: decrement row_q.
  - Otherwise: col_q = (col_q + 1) wrapping COLUNAS−1 → 0, row_q = LINHAS−1, cols_tried++.
  - When cols_tried reaches COLUNAS: pulse `no_target`, reload the counter with R, go to IDLE.
- State ISSUE:
  - `fire_valid` = 1; `fire_col/row/idx` held stable.
  - On `fire_valid & fire_ready`: reload counter with R, go to IDLE.
  - Abort: if the target's alive bit drops before acceptance, deassert `fire_valid`, reload, go to IDLE. No retarget.
- `enable` low in any state: next state is IDLE, `fire_valid` = 0, counter loaded with R. The counter is held at R while `enable` stays low.

## Timing
- All outputs and state are registered.
- Reset values: `fire_valid` 0, `fire_col` 0, `fire_row` 0, `fire_idx` 0, `no_target` 0, state IDLE, counter = FIRE_PERIOD, lfsr = LFSR_SEED.
- Latency from counter-expiry cycle to `fire_valid` = 2 + k cycles, where k = cells rejected before the hit.
  - Maximum k = LINHAS*COLUNAS − 1.
- A handshake completes in the cycle `fire_valid & fire_ready` are both high.
  - `fire_valid` is low the next cycle.
  - The counter restarts at R in that same next cycle.
- Reset asserted mid-SCAN or mid-ISSUE: all outputs return to reset values immediately (asynchronous); no request survives.
- `speed_level` is sampled at each reload only; a change during the countdown has no effect until the next reload.

## Structure
- Shared package `space_invaders_pkg`:
  - LINHAS, COLUNAS.
  - Index widths COL_W = 4, ROW_W = 2, IDX_W = 6.
  - State enum {IDLE, PICK, SCAN, ISSUE}.
- Sub-module `lfsr16`: clk, reset, seed parameter, 16-bit state output. Reusable for other game randomness.
- Remaining logic (counter, scan FSM, reload arithmetic) stays in `enemy_fire_scheduler`.

## Test plan
Bench parameters: FIRE_PERIOD = 16, SPEED_STEP = 4, MIN_PERIOD = 4.
- Reset release, `enable` = 1, all 40 alive → first `fire_valid` after 16 + 2 + 0 cycles; `fire_row` = 3; `fire_idx` = 30 + `fire_col`.
- Only index 37 alive → every shot reports col 7, row 3, idx 37, for any LFSR value; latency ≤ 2 + 39.
- Only index 2 alive, LFSR column 9 → scan wraps 9 → 0 → 1 → 2; result row 0, col 2, idx 2.
- All alive bits 0 → `no_target` pulses after exactly 40 SCAN cycles; `fire_valid` never rises.
- Hold `fire_ready` = 0 for 5 cycles, then clear the target's alive bit → `fire_valid` falls next cycle, no handshake, counter = R.
- `speed_level` = 5 → R = max(16 − 20, 4) = 4. With `shot_busy` = 1 at expiry, no request until `shot_busy` falls, then PICK follows on the next cycle.

Source files
------------

// File: rtl/space_invaders_pkg.sv
// Shared game constants, index widths, scheduler state encoding and the
// fire-reload arithmetic used by the enemy fire scheduler.
package space_invaders_pkg;

  localparam int LINHAS  = 4;
  localparam int COLUNAS = 10;

  localparam int COL_W = 4;
  localparam int ROW_W = 2;
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    SCAN  = 2'd2,
    ISSUE = 2'd3
  } fire_state_e;

  // max(base - speed*step, floor) in 24-bit unsigned; an underflowing
  // subtraction (product larger than base) also collapses to the floor.
  function automatic logic [23:0] reload_value(input logic [4:0]  speed,
                                               input logic [23:0] base,
                                               input logic [23:0] step,
                                               input logic [23:0] floor);
    logic [23:0] dec;
    logic [23:0] diff;
    dec  = 24'(speed) * step;
    diff = base - dec;
    if ((dec > base) || (diff < floor)) return floor;
    return diff;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, advancing every clock outside reset; reusable source
// of game randomness.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEED;
    else       state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
  end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Paces enemy shots with a speed-scaled reload counter, picks the lowest
// living alien starting from a random column, and offers it over valid/ready.
module enemy_fire_scheduler #(
  parameter int          LINHAS      = 4,
  parameter int          COLUNAS     = 10,
  parameter logic [23:0] FIRE_PERIOD = 24'd6_000_000,
  parameter logic [23:0] SPEED_STEP  = 24'd250_000,
  parameter logic [23:0] MIN_PERIOD  = 24'd1_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [LINHAS*COLUNAS-1:0] vivo_inimigo,
  input  logic [4:0]                speed_level,
  input  logic                      shot_busy,
  input  logic                      fire_ready,
  output logic                      fire_valid,
  output logic [3:0]                fire_col,
  output logic [1:0]                fire_row,
  output logic [5:0]                fire_idx,
  output logic                      no_target
);
  import space_invaders_pkg::*;

  localparam int TRY_W = COL_W + 1;

  fire_state_e        state_q, state_d;
  logic [23:0]        cnt_q, cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [TRY_W-1:0]   tried_q, tried_d;
  logic               valid_d, no_target_d;
  logic [COL_W-1:0]   fcol_d;
  logic [ROW_W-1:0]   frow_d;
  logic [IDX_W-1:0]   fidx_d;

  logic [15:0]        lfsr;
  logic [COL_W:0]     lfsr_col;
  logic [COL_W-1:0]   cand_col;
  logic [IDX_W-1:0]   scan_idx;
  logic               scan_alive;
  logic               target_alive;
  logic [23:0]        reload;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  // Fold the 4-bit random nibble into 0..COLUNAS-1 with a single subtract.
  assign lfsr_col = {1'b0, lfsr[3:0]};
  assign cand_col = (lfsr_col < TRY_W'(COLUNAS)) ? lfsr[3:0]
                                                 : COL_W'(lfsr_col - TRY_W'(COLUNAS));

  assign scan_idx     = IDX_W'(row_q) * IDX_W'(COLUNAS) + IDX_W'(col_q);
  assign scan_alive   = vivo_inimigo[scan_idx];
  assign target_alive = vivo_inimigo[fire_idx];
  assign reload       = reload_value(speed_level, FIRE_PERIOD, SPEED_STEP, MIN_PERIOD);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    tried_d     = tried_q;
    valid_d     = fire_valid;
    fcol_d      = fire_col;
    frow_d      = fire_row;
    fidx_d      = fire_idx;
    no_target_d = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = reload;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        // Expiry is taken on the 1->0 step so PICK coincides with the
        // counter reaching zero; a busy shot parks the counter at zero.
        IDLE: begin
          if (cnt_q <= 24'd1) begin
            cnt_d = '0;
            if (!shot_busy) state_d = PICK;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        PICK: begin
          col_d   = cand_col;
          row_d   = ROW_W'(LINHAS - 1);
          tried_d = '0;
          state_d = SCAN;
        end
        SCAN: begin
          if (scan_alive) begin
            state_d = ISSUE;
            valid_d = 1'b1;
            fcol_d  = col_q;
            frow_d  = row_q;
            fidx_d  = scan_idx;
          end else if (row_q != '0) begin
            row_d = row_q - ROW_W'(1);
          end else if (tried_q == TRY_W'(COLUNAS - 1)) begin
            no_target_d = 1'b1;
            cnt_d       = reload;
            state_d     = IDLE;
          end else begin
            col_d   = (col_q == COL_W'(COLUNAS - 1)) ? '0 : col_q + COL_W'(1);
            row_d   = ROW_W'(LINHAS - 1);
            tried_d = tried_q + TRY_W'(1);
          end
        end
        // A handshake in the same cycle the target dies still counts as fired.
        ISSUE: begin
          if ((fire_valid && fire_ready) || !target_alive) begin
            valid_d = 1'b0;
            cnt_d   = reload;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= FIRE_PERIOD;
      col_q      <= '0;
      row_q      <= '0;
      tried_q    <= '0;
      fire_valid <= 1'b0;
      fire_col   <= '0;
      fire_row   <= '0;
      fire_idx   <= '0;
      no_target  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      tried_q    <= tried_d;
      fire_valid <= valid_d;
      fire_col   <= fcol_d;
      fire_row   <= frow_d;
      fire_idx   <= fidx_d;
      no_target  <= no_target_d;
    end
  end

endmodule
